reg_file: RTL and testbench



---
 rtl/reg_file_pkg.sv | 14 +
 rtl/reg_file_cell.sv | 22 ++
 rtl/reg_file.sv | 45 ++++
 tb/tb_reg_file.sv | 138 +++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared widths and register mnemonics for the register file, decoder and ALU control.
package reg_file_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    localparam logic [ADDR_W_DEF-1:0] R0 = 3'd0;
    localparam logic [ADDR_W_DEF-1:0] R1 = 3'd1;
    localparam logic [ADDR_W_DEF-1:0] R2 = 3'd2;
    localparam logic [ADDR_W_DEF-1:0] R3 = 3'd3;
    localparam logic [ADDR_W_DEF-1:0] R4 = 3'd4;
    localparam logic [ADDR_W_DEF-1:0] R5 = 3'd5;
    localparam logic [ADDR_W_DEF-1:0] R6 = 3'd6;
    localparam logic [ADDR_W_DEF-1:0] R7 = 3'd7;
endpackage

// File: rtl/reg_file_cell.sv
// Load-enabled register with async active-low clear; q updates one edge after load.
// No backpressure: holds its value through mux2 feedback whenever load is low.
module reg_cell
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] q_nxt;

    assign q_nxt = load ? d : q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= q_nxt;
    end
endmodule

// File: rtl/reg_file.sv
// 2**ADDR_W x DATA_W register file: one synchronous write port, two combinational reads.
// Reads are zero-latency with no write bypass; writes land on the edge; no backpressure.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] d_in,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] d_out_a,
    output logic [DATA_W-1:0] d_out_b
);
    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        if (ZERO_R0 && i == 0) begin : g_zero
            // Constant slot: writes to address 0 decode to nothing and reads return 0.
            assign regs[i] = '0;
        end else begin : g_cell
            logic load;

            assign load = wr && (wr_addr == ADDR_W'(i));

            reg_cell #(.DATA_W(DATA_W)) u_cell (
                .clk   (clk),
                .rst_n (reset),
                .load  (load),
                .d     (d_in),
                .q     (regs[i])
            );
        end
    end

    assign d_out_a = regs[rd_addr_a];
    assign d_out_b = regs[rd_addr_b];
endmodule

// File: tb/tb_reg_file.sv
// Directed bench: two instances (ZERO_R0=1 and ZERO_R0=0) share stimulus.
module tb_reg_file;
    import reg_file_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] d_in = '0;
    logic [2:0]  rd_addr_a = '0;
    logic [2:0]  rd_addr_b = '0;
    logic [15:0] d_out_a, d_out_b;
    logic [15:0] nz_out_a, nz_out_b;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    reg_file #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(1'b1)) dut (
        .clk(clk), .reset(reset), .wr(wr), .wr_addr(wr_addr), .d_in(d_in),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .d_out_a(d_out_a), .d_out_b(d_out_b)
    );

    reg_file #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(1'b0)) dut_nz (
        .clk(clk), .reset(reset), .wr(wr), .wr_addr(wr_addr), .d_in(d_in),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .d_out_a(nz_out_a), .d_out_b(nz_out_b)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Drives one write for the next rising edge; wr is left high so back-to-back calls hit consecutive edges.
    task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        wr = 1'b1; wr_addr = a; d_in = d;
    endtask

    task automatic idle;
        @(negedge clk);
        wr = 1'b0;
    endtask

    initial begin
        // Reset state
        rd_addr_a = R3; rd_addr_b = R7;
        #3;
        chk("rst_a", d_out_a, 16'h0000);
        chk("rst_b", d_out_b, 16'h0000);
        chk("rst_nz_a", nz_out_a, 16'h0000);
        #9 reset = 1'b1;

        // Async reset clear mid-cycle
        wr_reg(R3, 16'hBEEF);
        idle();
        #1 chk("preload_r3", d_out_a, 16'hBEEF);
        #1 reset = 1'b0;
        #1 chk("async_clr_r3", d_out_a, 16'h0000);
        chk("async_clr_nz_r3", nz_out_a, 16'h0000);
        #1 reset = 1'b1;

        // Write / readback on consecutive edges
        wr_reg(R1, 16'h1234);
        wr_reg(R5, 16'hA5A5);
        wr_reg(R7, 16'hFFFF);
        idle();
        rd_addr_a = R1; rd_addr_b = R5;
        #1 chk("rd_r1_a", d_out_a, 16'h1234);
        chk("rd_r5_b", d_out_b, 16'hA5A5);
        rd_addr_a = R7; rd_addr_b = R1;
        #1 chk("rd_r7_a", d_out_a, 16'hFFFF);
        chk("rd_r1_b", d_out_b, 16'h1234);
        rd_addr_a = R5; rd_addr_b = R5;
        #1 chk("same_addr_a", d_out_a, 16'hA5A5);
        chk("same_addr_b", d_out_b, 16'hA5A5);

        // Read-during-write: old value before the edge, new after
        wr_reg(R2, 16'h0011);
        wr_reg(R2, 16'h0022);
        rd_addr_a = R2;
        #1 chk("rdw_before", d_out_a, 16'h0011);
        idle();
        #1 chk("rdw_after", d_out_a, 16'h0022);

        // Write disabled for three edges
        @(negedge clk);
        wr = 1'b0; wr_addr = R4; d_in = 16'hDEAD;
        repeat (3) @(negedge clk);
        rd_addr_a = R4;
        #1 chk("wr_dis_r4", d_out_a, 16'h0000);
        chk("wr_dis_nz_r4", nz_out_a, 16'h0000);

        // Isolation: R3 was cleared by the async reset above, R5 keeps A5A5
        wr_reg(R4, 16'h00FF);
        idle();
        rd_addr_a = R4; rd_addr_b = R3;
        #1 chk("iso_r4", d_out_a, 16'h00FF);
        chk("iso_r3", d_out_b, 16'h0000);
        rd_addr_b = R5;
        #1 chk("iso_r5", d_out_b, 16'hA5A5);

        // R0 hardwiring
        wr_reg(R0, 16'h5555);
        idle();
        rd_addr_a = R0; rd_addr_b = R0;
        #1 chk("r0_zero_a", d_out_a, 16'h0000);
        chk("r0_zero_b", d_out_b, 16'h0000);
        chk("r0_plain_a", nz_out_a, 16'h5555);
        chk("r0_plain_b", nz_out_b, 16'h5555);
        rd_addr_a = R1;
        #1 chk("r0_wr_no_side_r1", d_out_a, 16'h1234);

        // Reset held across an edge beats a write
        @(negedge clk);
        wr = 1'b1; wr_addr = R6; d_in = 16'h7777; reset = 1'b0;
        @(negedge clk);
        wr = 1'b0; reset = 1'b1;
        rd_addr_a = R6; rd_addr_b = R5;
        #1 chk("rst_vs_wr_r6", d_out_a, 16'h0000);
        chk("rst_vs_wr_nz_r6", nz_out_a, 16'h0000);
        chk("rst_clr_r5", d_out_b, 16'h0000);
        rd_addr_b = R0;
        #1 chk("rst_clr_nz_r0", nz_out_b, 16'h0000);

        // First write after release lands normally
        wr_reg(R6, 16'h0606);
        idle();
        #1 chk("post_rst_r6", d_out_a, 16'h0606);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
